// File: rtl/boolfn_equiv_sweeper_pkg.sv
// Shared definitions for the Boolean-function equivalence sweeper:
// FSM state encodings and parameter legality helper.
package boolfn_equiv_sweeper_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam int MAX_N_IN = 16;

  function automatic bit params_legal(input int n_in, input int num_impl, input int settle);
    return (n_in >= 1) && (n_in <= MAX_N_IN) && (num_impl >= 1) && (settle >= 1);
  endfunction

endpackage

// File: rtl/boolfn_equiv_sweeper_vec_counter.sv
// Settle timer plus input-vector counter for the sweeper. sample_en_o flags the
// last settle cycle of a vector; last_o flags the final vector of the sweep.
module boolfn_equiv_sweeper_vec_counter #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            settle_en_i,
  input  logic            advance_i,
  output logic [N_IN-1:0] vec_o,
  output logic            sample_en_o,
  output logic            last_o
);

  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] vec_q, vec_d;

  assign sample_en_o = settle_en_i && (cnt_q == CNT_LAST);
  assign last_o      = (vec_q == VEC_LAST);
  assign vec_o       = vec_q;

  // Next-state for settle timer and vector counter
  always_comb begin
    cnt_d = cnt_q;
    vec_d = vec_q;
    if (clear_i) begin
      cnt_d = '0;
      vec_d = '0;
    end else if (settle_en_i) begin
      cnt_d = sample_en_o ? '0 : (cnt_q + CNT_ONE);
    end else if (advance_i) begin
      cnt_d = '0;
      vec_d = vec_q + VEC_ONE;
    end else begin
      cnt_d = cnt_q;
      vec_d = vec_q;
    end
  end

  // Timer and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      vec_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vec_q <= vec_d;
    end
  end

endmodule

// File: rtl/boolfn_equiv_sweeper.sv
// Exhaustive sweeper: drives every input vector, then compares NUM_IMPL
// implementation outputs against a reference and accumulates mismatch results.
module boolfn_equiv_sweeper
  import boolfn_equiv_sweeper_pkg::*;
#(
  parameter int N_IN     = 3,
  parameter int NUM_IMPL = 6,
  parameter int SETTLE   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [N_IN-1:0]     vec,
  input  logic                ref_out,
  input  logic [NUM_IMPL-1:0] impl_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_IN:0]       err_count,
  output logic [N_IN-1:0]     first_fail_vec,
  output logic [NUM_IMPL-1:0] first_fail_msk,
  output logic [NUM_IMPL-1:0] fail_accum
);

  if (!params_legal(N_IN, NUM_IMPL, SETTLE)) begin : g_param_check
    $error("boolfn_equiv_sweeper: illegal N_IN/NUM_IMPL/SETTLE");
  end

  localparam logic [N_IN:0] ERR_ONE = (N_IN + 1)'(1);

  state_e              state_q, state_d;
  logic                busy_q, done_q;
  logic [N_IN:0]       err_q, err_d;
  logic [N_IN-1:0]     ffv_q, ffv_d;
  logic [NUM_IMPL-1:0] ffm_q, ffm_d;
  logic [NUM_IMPL-1:0] acc_q, acc_d;
  logic                sweep_start_s, sample_upd_s, settle_en_s, advance_s, clear_s;
  logic                sample_en_s, last_s;
  logic [NUM_IMPL-1:0] msk_s;

  assign msk_s        = impl_out ^ {NUM_IMPL{ref_out}};
  assign sample_upd_s = (state_q == S_SAMPLE) && !abort;
  assign settle_en_s  = (state_q == S_APPLY) && !abort;
  assign advance_s    = sample_upd_s && !last_s;
  assign clear_s      = sweep_start_s || (abort && (state_q != S_IDLE));

  boolfn_equiv_sweeper_vec_counter #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_vec_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear_s),
    .settle_en_i (settle_en_s),
    .advance_i   (advance_s),
    .vec_o       (vec),
    .sample_en_o (sample_en_s),
    .last_o      (last_s)
  );

  // FSM next state; abort outranks start and the sample update
  always_comb begin
    state_d       = state_q;
    sweep_start_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!abort && start) begin
          state_d       = S_APPLY;
          sweep_start_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_APPLY: begin
        if (abort)            state_d = S_IDLE;
        else if (sample_en_s) state_d = S_SAMPLE;
        else                  state_d = S_APPLY;
      end
      S_SAMPLE: begin
        if (abort)       state_d = S_IDLE;
        else if (last_s) state_d = S_DONE;
        else             state_d = S_APPLY;
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d       = S_APPLY;
          sweep_start_s = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result accumulation: cleared on sweep start, updated on a mismatching sample
  always_comb begin
    err_d = err_q;
    ffv_d = ffv_q;
    ffm_d = ffm_q;
    acc_d = acc_q;
    if (sweep_start_s) begin
      err_d = '0;
      ffv_d = '0;
      ffm_d = '0;
      acc_d = '0;
    end else if (sample_upd_s && (|msk_s)) begin
      err_d = err_q + ERR_ONE;
      acc_d = acc_q | msk_s;
      if (err_q == '0) begin
        ffv_d = vec;
        ffm_d = msk_s;
      end else begin
        ffv_d = ffv_q;
        ffm_d = ffm_q;
      end
    end else begin
      err_d = err_q;
    end
  end

  // State, status flags and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffm_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_APPLY) || (state_d == S_SAMPLE);
      done_q  <= (state_d == S_DONE);
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffm_q   <= ffm_d;
      acc_q   <= acc_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = done_q && (err_q == '0);
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;
  assign first_fail_msk = ffm_q;
  assign fail_accum     = acc_q;

endmodule

// File: tb/tb_boolfn_equiv_sweeper.sv
// Scoreboard bench: each accepted start pushes the hand-computed sweep result;
// a forked monitor pops and compares whenever done rises.
module tb_boolfn_equiv_sweeper;

  localparam int NA = 3, IA = 6, SA = 2;
  localparam int NB = 1, IB = 2, SB = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            start_a = 1'b0, abort_a = 1'b0;
  logic            ref_a, busy_a, done_a, pass_a;
  logic [NA-1:0]   vec_a, ffv_a;
  logic [NA:0]     err_a;
  logic [IA-1:0]   impl_a, ffm_a, acc_a;
  logic [IA-1:0]   flip_a [8];

  logic            start_b = 1'b0, abort_b = 1'b0;
  logic            ref_b, busy_b, done_b, pass_b;
  logic [NB-1:0]   vec_b, ffv_b;
  logic [NB:0]     err_b;
  logic [IB-1:0]   impl_b, ffm_b, acc_b;
  logic [IB-1:0]   flip_b [2];

  // Reference f = v0 ^ (v1 & v2); implementations differ only where flipped
  assign ref_a  = vec_a[0] ^ (vec_a[1] & vec_a[2]);
  assign impl_a = {IA{ref_a}} ^ flip_a[vec_a];
  assign ref_b  = vec_b[0];
  assign impl_b = {IB{ref_b}} ^ flip_b[vec_b];

  boolfn_equiv_sweeper #(.N_IN(NA), .NUM_IMPL(IA), .SETTLE(SA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .vec(vec_a),
    .ref_out(ref_a), .impl_out(impl_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail_vec(ffv_a), .first_fail_msk(ffm_a), .fail_accum(acc_a));

  boolfn_equiv_sweeper #(.N_IN(NB), .NUM_IMPL(IB), .SETTLE(SB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .vec(vec_b),
    .ref_out(ref_b), .impl_out(impl_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail_vec(ffv_b), .first_fail_msk(ffm_b), .fail_accum(acc_b));

  typedef struct {
    int err; int ffv; int ffm; int acc; int pas; int start_cyc; int lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int err, input int ffv, input int ffm, input int acc, input int lat);
    exp_t e;
    e.err = err; e.ffv = ffv; e.ffm = ffm; e.acc = acc;
    e.pas = (err == 0) ? 1 : 0; e.start_cyc = 0; e.lat = lat;
    return e;
  endfunction

  task automatic cmp_item(input string tag, input exp_t e, input int err, input int ffv,
                          input int ffm, input int acc, input int pas);
    chk({tag, "_err_count"}, err, e.err);
    chk({tag, "_first_fail_vec"}, ffv, e.ffv);
    chk({tag, "_first_fail_msk"}, ffm, e.ffm);
    chk({tag, "_fail_accum"}, acc, e.acc);
    chk({tag, "_pass"}, pas, e.pas);
    // Latency counted inclusive of the edge that samples start
    chk({tag, "_latency"}, cyc - e.start_cyc + 1, e.lat);
  endtask

  task automatic monitor();
    logic pd_a, pd_b;
    exp_t e;
    pd_a = 1'b0;
    pd_b = 1'b0;
    forever begin
      @(negedge clk);
      if (done_a && !pd_a) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected_done: done rose with no sweep outstanding");
        end else begin
          e = q_a.pop_front();
          cmp_item("a", e, int'(err_a), int'(ffv_a), int'(ffm_a), int'(acc_a), int'(pass_a));
        end
      end
      if (done_b && !pd_b) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected_done: done rose with no sweep outstanding");
        end else begin
          e = q_b.pop_front();
          cmp_item("b", e, int'(err_b), int'(ffv_b), int'(ffm_b), int'(acc_b), int'(pass_b));
        end
      end
      pd_a = done_a;
      pd_b = done_b;
    end
  endtask

  task automatic go_a(input exp_t e);
    exp_t x;
    x = e;
    x.start_cyc = cyc + 1;
    q_a.push_back(x);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic go_b(input exp_t e);
    exp_t x;
    x = e;
    x.start_cyc = cyc + 1;
    q_b.push_back(x);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n;
    n = 0;
    while (!done_a && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_reached"}, int'(done_a), 1);
  endtask

  task automatic wait_done_b(input string tag);
    int n;
    n = 0;
    while (!done_b && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_reached"}, int'(done_b), 1);
  endtask

  task automatic clear_flips();
    for (int i = 0; i < 8; i++) flip_a[i] = '0;
    for (int i = 0; i < 2; i++) flip_b[i] = '0;
  endtask

  initial begin
    int n;
    clear_flips();
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_vec", int'(vec_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_pass", int'(pass_a), 0);
    chk("rst_err", int'(err_a), 0);
    chk("rst_acc", int'(acc_a), 0);
    chk("rst_b_vec", int'(vec_b), 0);
    chk("rst_b_busy", int'(busy_b), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All implementations match; extra start pulses while busy must be ignored
    go_a(mk(0, 0, 0, 0, 25));
    repeat (4) @(negedge clk);
    chk("t1_busy", int'(busy_a), 1);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    repeat (7) @(negedge clk);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    wait_done_a("t1");

    // Single failure at vec 5 on impl 1, restarted straight from DONE
    flip_a[5] = 6'b000010;
    go_a(mk(1, 5, 6'b000010, 6'b000010, 25));
    wait_done_a("t2");

    clear_flips();
    flip_a[2] = 6'b000001;
    flip_a[6] = 6'b010001;
    go_a(mk(2, 2, 6'b000001, 6'b010001, 25));
    wait_done_a("t3");

    for (int i = 0; i < 8; i++) flip_a[i] = 6'b111111;
    go_a(mk(8, 0, 6'b111111, 6'b111111, 25));
    wait_done_a("t4");

    // Abort at vec 4 (with a coincident start): partial results retained
    clear_flips();
    flip_a[2] = 6'b000001;
    flip_a[6] = 6'b010001;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    n = 0;
    while (vec_a != 3'd4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_vec4", int'(vec_a), 4);
    abort_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    start_a = 1'b0;
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_done", int'(done_a), 0);
    chk("abort_vec", int'(vec_a), 0);
    chk("abort_err", int'(err_a), 1);
    chk("abort_ffv", int'(ffv_a), 2);
    chk("abort_ffm", int'(ffm_a), 1);
    chk("abort_acc", int'(acc_a), 1);
    abort_a = 1'b1; @(negedge clk); abort_a = 1'b0;
    chk("idle_abort_busy", int'(busy_a), 0);
    chk("idle_abort_err", int'(err_a), 1);

    // Reset mid-sweep discards progress; the restart runs the full length
    clear_flips();
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_vec", int'(vec_a), 0);
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_done", int'(done_a), 0);
    chk("midrst_err", int'(err_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go_a(mk(0, 0, 0, 0, 25));
    wait_done_a("t6");

    // Abort outranks start while in DONE
    abort_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    start_a = 1'b0;
    chk("done_abort_done", int'(done_a), 0);
    chk("done_abort_busy", int'(busy_a), 0);
    chk("done_abort_vec", int'(vec_a), 0);

    // N_IN=1, SETTLE=1 corner, then restart from DONE clears results
    flip_b[1] = 2'b10;
    go_b(mk(1, 1, 2'b10, 2'b10, 5));
    wait_done_b("b1");
    clear_flips();
    go_b(mk(0, 0, 0, 0, 5));
    wait_done_b("b2");

    repeat (3) @(negedge clk);
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
